fft_sram_bank: RTL and testbench
================================

FFT_SRAM_BANK -- requirements
Module: fft_sram_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 128, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, number of words; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 and 2.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rstn, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have ports i_raddress1/i_raddress2, input, ADDR_W each: FFT read addresses.
REQ-007 SHALL have ports o_rdata1/o_rdata2, output, DATA_W each: FFT read data.
REQ-008 SHALL have ports i_waddress1/i_waddress2 (input, ADDR_W) and i_wdata1/i_wdata2 (input, DATA_W): FFT write ports.
REQ-009 SHALL have port i_global_write_enable, input, 1: commits both FFT writes in the same cycle.
REQ-010 SHALL have port i_fft_active, input, 1: FFT engine requests ownership of the array.
REQ-011 SHALL have ports i_host_valid (in, 1), o_host_ready (out, 1), i_host_write (in, 1; 1 = load, 0 = dump), i_host_addr (in, ADDR_W), i_host_wdata (in, DATA_W).
REQ-012 SHALL have ports o_host_rvalid (out, 1) and o_host_rdata (out, DATA_W): dump return channel.
REQ-013 SHALL have ports o_busy (out, 1; state != IDLE), o_collision (out, 1; sticky), i_clear_status (in, 1).

Function
REQ-014 SHALL implement a controller with states IDLE, FFT, HOST_RD.
REQ-015 IDLE -> FFT when i_fft_active=1; i_fft_active takes priority over a simultaneous i_host_valid.
REQ-016 FFT -> IDLE when i_fft_active=0 and no FFT read remains in the latency pipeline.
REQ-017 In IDLE, a host beat with i_host_write=1 and o_host_ready=1 writes i_host_wdata to i_host_addr at that edge; the state stays IDLE.
REQ-018 In IDLE, a host beat with i_host_write=0 moves to HOST_RD; the state returns to IDLE once o_host_rvalid has pulsed.
REQ-019 o_host_ready SHALL be 1 only in IDLE with i_fft_active=0.
REQ-020 In FFT, the array is read at i_raddress1/2 every cycle; o_rdata1/2 present the word RD_LAT cycles after the address.
REQ-021 In FFT, i_global_write_enable=1 writes i_wdata1 to i_waddress1 and i_wdata2 to i_waddress2 at the edge.
REQ-022 Outside FFT, i_global_write_enable and FFT addresses are ignored; o_rdata1/2 hold their last value.
REQ-023 Same-cycle read and write to one address: read-first; the read returns the pre-write word.
REQ-024 i_waddress1 == i_waddress2 with i_global_write_enable=1: port 2 data is stored and o_collision sets the next cycle.
REQ-025 o_collision stays 1 until i_clear_status=1; if a clear and a new collision coincide, set wins.
REQ-026 o_host_rvalid is a one-cycle pulse RD_LAT cycles after the dump beat is accepted, with o_host_rdata = word at i_host_addr.
REQ-027 o_host_rdata SHALL hold its value until the next dump.
REQ-028 Addresses SHALL wrap modulo DEPTH; no out-of-range detection is required.

Reset
REQ-029 rstn=0 SHALL force state IDLE, o_rdata1/2=0, o_host_rdata=0, o_host_rvalid=0, o_collision=0, o_busy=0 and flush the read pipeline.
REQ-030 Array contents SHALL NOT be reset; they are retained across reset.
REQ-031 Reset asserted mid-FFT or mid-dump SHALL abort the operation; no write commits on or after the reset edge.
REQ-032 Host accepts are allowed from the first edge after rstn deasserts, when i_fft_active=0.

Verification
REQ-033 Load and dump: RD_LAT=1; load addr 5 = 0x...A5, then dump addr 5 -> o_host_rvalid 1 cycle after the accept, data 0x...A5, o_busy=1 for 1 cycle.
REQ-034 FFT latency: RD_LAT=2, i_fft_active=1, i_raddress1=5 at cycle t -> o_rdata1=0x...A5 at cycle t+2; host beat in the same window -> o_host_ready=0.
REQ-035 Read-first: FFT write addr 7=0x22 while reading addr 7 (old 0x11) -> o_rdata1=0x11 at the next cycle, then 0x22 on the following read.
REQ-036 Collision: both write ports at addr 3, wdata1=0x1, wdata2=0x2 -> mem[3]=0x2, o_collision=1 until i_clear_status; simultaneous clear and collision -> stays 1.
REQ-037 Arbitration: i_fft_active and i_host_valid both rise in IDLE -> state FFT, no host accept.
REQ-038 Reset: rstn=0 mid-dump -> o_host_rvalid never pulses, outputs 0, and a previously loaded mem[5] is still 0x...A5 after reset.

Source files
------------

// File: rtl/fft_sram_bank.sv
// Shared coefficient/sample array arbitrated between an FFT engine (2R/2W) and a host load/dump port.
// Latency: FFT reads and host dumps return data RD_LAT (1 or 2) cycles after the address is sampled.
// Backpressure: host is stalled (o_host_ready=0) unless idle with no FFT request; FFT side never stalls.
module fft_sram_bank #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    // FFT engine side
    input  logic [ADDR_W-1:0] i_raddress1,
    input  logic [ADDR_W-1:0] i_raddress2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic [ADDR_W-1:0] i_waddress1,
    input  logic [ADDR_W-1:0] i_waddress2,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic [DATA_W-1:0] i_wdata2,
    input  logic              i_global_write_enable,
    input  logic              i_fft_active,
    // host load/dump side
    input  logic              i_host_valid,
    output logic              o_host_ready,
    input  logic              i_host_write,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    // status
    output logic              o_busy,
    output logic              o_collision,
    input  logic              i_clear_status
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FFT     = 2'd1,
        ST_HOST_RD = 2'd2
    } state_t;

    // Selects the in-flight read stages; the last stage already holds delivered
    // data, so only the earlier stages keep the FFT state from being released.
    localparam int PEND_BITS = (1 << (RD_LAT - 1)) - 1;

    // Storage array: deliberately no reset so contents survive rstn pulses.
    // Addresses are ADDR_W bits wide, so they wrap modulo DEPTH for power-of-two depths.
    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              collision_q, collision_d;

    // FFT read pipeline: stage 0 captures the array, the last stage drives o_rdata1/2.
    logic [RD_LAT-1:0] fvld_q, fvld_d;
    logic [DATA_W-1:0] fdat1_q [RD_LAT];
    logic [DATA_W-1:0] fdat1_d [RD_LAT];
    logic [DATA_W-1:0] fdat2_q [RD_LAT];
    logic [DATA_W-1:0] fdat2_d [RD_LAT];

    // Host dump pipeline: the last stage drives o_host_rvalid/o_host_rdata.
    logic [RD_LAT-1:0] hvld_q, hvld_d;
    logic [DATA_W-1:0] hdat_q [RD_LAT];
    logic [DATA_W-1:0] hdat_d [RD_LAT];

    logic host_rdy;
    logic host_wr_en;
    logic host_rd_go;
    logic fft_rd_go;
    logic fft_wr_en;
    logic coll_set;
    logic fft_pend;

    // Qualify every array access by the owner of the current state.
    always_comb begin
        // Holding ready low during reset keeps host loads from landing while rstn is asserted.
        host_rdy   = rstn && (state_q == ST_IDLE) && !i_fft_active;
        host_wr_en = i_host_valid && host_rdy && i_host_write;
        host_rd_go = i_host_valid && host_rdy && !i_host_write;
        // A new FFT read is only issued while the engine still asks for the array,
        // which lets the pipeline drain once i_fft_active drops.
        fft_rd_go  = (state_q == ST_FFT) && i_fft_active;
        fft_wr_en  = (state_q == ST_FFT) && i_global_write_enable;
        coll_set   = fft_wr_en && (i_waddress1 == i_waddress2);
        fft_pend   = |(fvld_q & PEND_BITS[RD_LAT-1:0]);
    end

    // Next-state logic for the ownership controller and its registered busy flag.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_fft_active) begin
                    state_d = ST_FFT;
                end else if (host_rd_go) begin
                    state_d = ST_HOST_RD;
                end
            end
            ST_FFT: begin
                if (!i_fft_active && !fft_pend) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOST_RD: begin
                // Release ownership on the edge that ends the rvalid pulse.
                if (hvld_q[RD_LAT-1]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sticky collision flag; a new collision beats a simultaneous clear.
    always_comb begin
        collision_d = coll_set | (collision_q & ~i_clear_status);
    end

    // FFT read pipeline: stages only advance on valid data so outputs hold between reads.
    always_comb begin
        fvld_d    = '0;
        fdat1_d   = fdat1_q;
        fdat2_d   = fdat2_q;
        fvld_d[0] = fft_rd_go;
        // Combinational array read before this edge's write gives read-first ordering.
        if (fft_rd_go) begin
            fdat1_d[0] = mem_q[i_raddress1];
            fdat2_d[0] = mem_q[i_raddress2];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            fvld_d[i] = fvld_q[i-1];
            if (fvld_q[i-1]) begin
                fdat1_d[i] = fdat1_q[i-1];
                fdat2_d[i] = fdat2_q[i-1];
            end
        end
    end

    // Host dump pipeline: same shape as the FFT path, single read port.
    always_comb begin
        hvld_d    = '0;
        hdat_d    = hdat_q;
        hvld_d[0] = host_rd_go;
        if (host_rd_go) begin
            hdat_d[0] = mem_q[i_host_addr];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            hvld_d[i] = hvld_q[i-1];
            if (hvld_q[i-1]) begin
                hdat_d[i] = hdat_q[i-1];
            end
        end
    end

    // Control and read-pipeline registers; reset aborts any in-flight read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            collision_q <= 1'b0;
            fvld_q      <= '0;
            hvld_q      <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                fdat1_q[i] <= '0;
                fdat2_q[i] <= '0;
                hdat_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            collision_q <= collision_d;
            fvld_q      <= fvld_d;
            hvld_q      <= hvld_d;
            fdat1_q     <= fdat1_d;
            fdat2_q     <= fdat2_d;
            hdat_q      <= hdat_d;
        end
    end

    // Array write ports; port 2 is written last so it wins an address clash.
    // Host and FFT writes are exclusive because they require different states.
    always_ff @(posedge clk) begin
        if (host_wr_en) begin
            mem_q[i_host_addr] <= i_host_wdata;
        end
        if (fft_wr_en) begin
            mem_q[i_waddress1] <= i_wdata1;
            mem_q[i_waddress2] <= i_wdata2;
        end
    end

    assign o_rdata1      = fdat1_q[RD_LAT-1];
    assign o_rdata2      = fdat2_q[RD_LAT-1];
    assign o_host_rvalid = hvld_q[RD_LAT-1];
    assign o_host_rdata  = hdat_q[RD_LAT-1];
    assign o_host_ready  = host_rdy;
    assign o_busy        = busy_q;
    assign o_collision   = collision_q;

endmodule

// File: tb/tb_fft_sram_bank.sv
// Bench for fft_sram_bank: one RD_LAT=1 and one RD_LAT=2 instance share all stimulus.
// Expected outputs come from a transaction-level model (array + issue history per edge).
// Directed sequences pin load/dump, FFT latency, read-first, collision, arbitration and reset.
module tb_fft_sram_bank;

    localparam int DW  = 64;
    localparam int DEP = 16;
    localparam int AW  = 4;
    localparam int NC  = 1024;

    localparam logic [DW-1:0] W_A5  = 64'h5555_AAAA_0000_00A5;
    localparam logic [DW-1:0] W_OLD = 64'h11;
    localparam logic [DW-1:0] W_NEW = 64'h22;
    localparam logic [DW-1:0] W_BAD = 64'hBAD0_BAD0_BAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn = 1'b0;
    logic [AW-1:0] raddr1 = '0, raddr2 = '0, waddr1 = '0, waddr2 = '0, host_addr = '0;
    logic [DW-1:0] wdata1 = '0, wdata2 = '0, host_wdata = '0;
    logic          gwe = 1'b0, fft_active = 1'b0, host_valid = 1'b0, host_write = 1'b0, clear = 1'b0;

    logic [DW-1:0] rd1 [2];
    logic [DW-1:0] rd2 [2];
    logic [DW-1:0] hrd [2];
    logic          hrdy [2];
    logic          hrv [2];
    logic          busy [2];
    logic          coll [2];

    fft_sram_bank #(.DATA_W(DW), .DEPTH(DEP), .RD_LAT(1)) dut_l1 (
        .clk(clk), .rstn(rstn),
        .i_raddress1(raddr1), .i_raddress2(raddr2),
        .o_rdata1(rd1[0]), .o_rdata2(rd2[0]),
        .i_waddress1(waddr1), .i_waddress2(waddr2),
        .i_wdata1(wdata1), .i_wdata2(wdata2),
        .i_global_write_enable(gwe), .i_fft_active(fft_active),
        .i_host_valid(host_valid), .o_host_ready(hrdy[0]), .i_host_write(host_write),
        .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_rvalid(hrv[0]), .o_host_rdata(hrd[0]),
        .o_busy(busy[0]), .o_collision(coll[0]), .i_clear_status(clear)
    );

    fft_sram_bank #(.DATA_W(DW), .DEPTH(DEP), .RD_LAT(2)) dut_l2 (
        .clk(clk), .rstn(rstn),
        .i_raddress1(raddr1), .i_raddress2(raddr2),
        .o_rdata1(rd1[1]), .o_rdata2(rd2[1]),
        .i_waddress1(waddr1), .i_waddress2(waddr2),
        .i_wdata1(wdata1), .i_wdata2(wdata2),
        .i_global_write_enable(gwe), .i_fft_active(fft_active),
        .i_host_valid(host_valid), .o_host_ready(hrdy[1]), .i_host_write(host_write),
        .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_rvalid(hrv[1]), .o_host_rdata(hrd[1]),
        .o_busy(busy[1]), .o_collision(coll[1]), .i_clear_status(clear)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word(input int a);
        if (a == 5) return W_A5;
        if (a == 7) return W_OLD;
        return 64'hC0DE_0000_0000_0000 | 64'(a);
    endfunction

    // ---------------- model ----------------
    // Edge counter m; every accepted read is logged at the edge it was sampled.
    // An instance with latency L shows the most recent read logged at an edge
    // n <= m-L+1 that is later than the last reset (mark); otherwise zero.
    int            cyc = 0, mark = 0;
    int            mst [2] = '{0, 0};      // 0 idle, 1 fft, 2 host dump
    bit            mcoll [2] = '{0, 0};
    logic [DW-1:0] mm [2][DEP];
    bit            fi [2][NC];
    bit            hi [2][NC];
    logic [DW-1:0] fd1 [2][NC];
    logic [DW-1:0] fd2 [2][NC];
    logic [DW-1:0] hd [2][NC];
    logic [DW-1:0] e_rd1 [2], e_rd2 [2], e_hrd [2];
    bit            e_hrv [2];
    int            ml, mm_e, mst_c;
    bit            fpend, hprev;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mark = cyc;
            for (int k = 0; k < 2; k++) begin
                mst[k] = 0; mcoll[k] = 1'b0;
                e_rd1[k] = '0; e_rd2[k] = '0; e_hrd[k] = '0; e_hrv[k] = 1'b0;
            end
        end else begin
            cyc++;
            mm_e = cyc;
            for (int k = 0; k < 2; k++) begin
                ml    = k + 1;
                mst_c = mst[k];
                fpend = (ml == 2) && (mm_e - 1 > mark) && fi[k][mm_e-1];
                hprev = (mm_e - ml > mark) && hi[k][mm_e-ml];
                // reads see the array before this edge's writes
                fi[k][mm_e] = (mst_c == 1) && fft_active;
                fd1[k][mm_e] = mm[k][raddr1];
                fd2[k][mm_e] = mm[k][raddr2];
                hi[k][mm_e] = (mst_c == 0) && !fft_active && host_valid && !host_write;
                hd[k][mm_e] = mm[k][host_addr];
                if ((mst_c == 0) && !fft_active && host_valid && host_write)
                    mm[k][host_addr] = host_wdata;
                if ((mst_c == 1) && gwe) begin
                    mm[k][waddr1] = wdata1;
                    mm[k][waddr2] = wdata2;
                end
                if ((mst_c == 1) && gwe && (waddr1 == waddr2)) mcoll[k] = 1'b1;
                else if (clear) mcoll[k] = 1'b0;
                case (mst_c)
                    0: mst[k] = fft_active ? 1 : ((host_valid && !host_write) ? 2 : 0);
                    1: mst[k] = (!fft_active && !fpend) ? 0 : 1;
                    default: mst[k] = hprev ? 0 : 2;
                endcase
                e_rd1[k] = '0; e_rd2[k] = '0; e_hrd[k] = '0;
                for (int n = mm_e - ml + 1; n > mark; n--) begin
                    if (fi[k][n]) begin
                        e_rd1[k] = fd1[k][n]; e_rd2[k] = fd2[k][n];
                        break;
                    end
                end
                for (int n = mm_e - ml + 1; n > mark; n--) begin
                    if (hi[k][n]) begin
                        e_hrd[k] = hd[k][n];
                        break;
                    end
                end
                e_hrv[k] = (mm_e - ml + 1 > mark) && hi[k][mm_e-ml+1];
            end
        end
    end

    // Compare every output of both instances against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("L%0d rdata1", k + 1), rd1[k], e_rd1[k]);
                chk($sformatf("L%0d rdata2", k + 1), rd2[k], e_rd2[k]);
                chk($sformatf("L%0d host_rdata", k + 1), hrd[k], e_hrd[k]);
                chk($sformatf("L%0d host_rvalid", k + 1), DW'(hrv[k]), DW'(e_hrv[k]));
                chk($sformatf("L%0d busy", k + 1), DW'(busy[k]), DW'(mst[k] != 0));
                chk($sformatf("L%0d collision", k + 1), DW'(coll[k]), DW'(mcoll[k]));
                chk($sformatf("L%0d host_ready", k + 1), DW'(hrdy[k]),
                    DW'(rstn && (mst[k] == 0) && !fft_active));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (3) step();
        chk_on = 1'b1;
        chk("reset busy", DW'(busy[0]), '0);
        chk("reset collision", DW'(coll[1]), '0);
        chk("reset rdata1", rd1[1], '0);
        chk("reset host_rvalid", DW'(hrv[1]), '0);
        rstn = 1'b1;

        // preload every word, starting on the first edge after reset release
        for (int a = 0; a < DEP; a++) begin
            host_valid = 1'b1; host_write = 1'b1;
            host_addr = AW'(a); host_wdata = word(a);
            step();
        end
        host_valid = 1'b0;
        step();

        // load/dump of address 5
        host_valid = 1'b1; host_write = 1'b0; host_addr = 5;
        step();
        host_valid = 1'b0;
        chk("dump L1 rvalid", DW'(hrv[0]), 1);
        chk("dump L1 rdata", hrd[0], W_A5);
        chk("dump L1 busy", DW'(busy[0]), 1);
        step();
        chk("dump L1 rvalid drop", DW'(hrv[0]), 0);
        chk("dump L1 busy drop", DW'(busy[0]), 0);
        chk("dump L2 rvalid", DW'(hrv[1]), 1);
        chk("dump L2 rdata", hrd[1], W_A5);
        step();
        chk("dump L1 rdata hold", hrd[0], W_A5);
        step();

        // FFT latency, host stalled by an FFT request
        fft_active = 1'b1; raddr1 = 5; raddr2 = 7;
        host_valid = 1'b1; host_write = 1'b1; host_addr = 9; host_wdata = W_BAD;
        #1;
        chk("fft req L1 ready", DW'(hrdy[0]), 0);
        chk("fft req L2 ready", DW'(hrdy[1]), 0);
        step();
        host_valid = 1'b0;
        step();
        chk("fft L1 rdata1", rd1[0], W_A5);
        raddr1 = 0;
        step();
        chk("fft L2 rdata1", rd1[1], W_A5);
        chk("fft L2 rdata2", rd2[1], W_OLD);

        // read-first on address 7
        raddr1 = 7; gwe = 1'b1; waddr1 = 7; wdata1 = W_NEW; waddr2 = 8; wdata2 = 64'h88;
        step();
        chk("rdfirst L1 old", rd1[0], W_OLD);
        gwe = 1'b0;
        step();
        chk("rdfirst L1 new", rd1[0], W_NEW);
        chk("rdfirst L2 old", rd1[1], W_OLD);
        step();
        chk("rdfirst L2 new", rd1[1], W_NEW);

        // collision on address 3
        gwe = 1'b1; waddr1 = 3; waddr2 = 3; wdata1 = 64'h1; wdata2 = 64'h2;
        step();
        chk("coll L1 set", DW'(coll[0]), 1);
        chk("coll L2 set", DW'(coll[1]), 1);
        gwe = 1'b0; raddr1 = 3;
        step();
        step();
        chk("coll L1 mem3", rd1[0], 64'h2);
        chk("coll L2 mem3", rd1[1], 64'h2);
        gwe = 1'b1; clear = 1'b1;
        step();
        chk("coll set beats clear", DW'(coll[0]), 1);
        gwe = 1'b0;
        step();
        chk("coll clear L1", DW'(coll[0]), 0);
        chk("coll clear L2", DW'(coll[1]), 0);
        clear = 1'b0;

        // leave FFT
        fft_active = 1'b0;
        repeat (3) step();
        chk("fft exit L2 busy", DW'(busy[1]), 0);

        // simultaneous FFT request and host beat: FFT wins, no write
        fft_active = 1'b1;
        host_valid = 1'b1; host_write = 1'b1; host_addr = 9; host_wdata = W_BAD;
        step();
        chk("arb L1 busy", DW'(busy[0]), 1);
        chk("arb L2 busy", DW'(busy[1]), 1);
        fft_active = 1'b0; host_valid = 1'b0;
        repeat (3) step();
        host_valid = 1'b1; host_write = 1'b0; host_addr = 9;
        step();
        host_valid = 1'b0;
        chk("arb mem9 untouched", hrd[0], word(9));
        repeat (3) step();

        // reset in the middle of an RD_LAT=2 dump
        host_valid = 1'b1; host_write = 1'b0; host_addr = 5;
        step();
        rstn = 1'b0; host_valid = 1'b0;
        #1;
        chk("rst L2 host_rdata", hrd[1], '0);
        chk("rst L2 rdata1", rd1[1], '0);
        chk("rst L2 busy", DW'(busy[1]), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst L2 no rvalid", DW'(hrv[1]), 0);
        end
        rstn = 1'b1;
        host_valid = 1'b1; host_write = 1'b0; host_addr = 5;
        step();
        host_valid = 1'b0;
        step();
        chk("rst retain L2 rvalid", DW'(hrv[1]), 1);
        chk("rst retain L2 mem5", hrd[1], W_A5);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
